// File: rtl/fir_out_pkg.sv
// Shared widths, limits and defaults for the FIR output stage, plus the
// rounding/clamping quantizer used on every accepted sample.
package fir_out_pkg;

    localparam int Y_W        = 16;
    localparam int Q_W        = 8;
    localparam int SH_W       = 4;
    localparam int Q_MAX      = 127;
    localparam int Q_MIN      = -128;
    localparam int DEPTH_DEF  = 4;
    localparam int WARMUP_DEF = 2;

    typedef struct packed {
        logic [Q_W-1:0] q;
        logic           sat;
    } quant_t;

    // Round half up, arithmetic shift in Y_W+1 bits, then clamp to the Q_W range.
    function automatic quant_t quantize(input logic signed [Y_W-1:0] y,
                                        input logic [SH_W-1:0]       sh);
        logic signed [Y_W:0] ext;
        logic signed [Y_W:0] rnd;
        logic signed [Y_W:0] r;
        quant_t              res;
        ext = {y[Y_W-1], y};
        rnd = '0;
        if (sh != '0) begin
            rnd = {{Y_W{1'b0}}, 1'b1} << (sh - 1'b1);
        end
        r = (ext + rnd) >>> sh;
        if (r > Q_MAX) begin
            res.q   = Q_W'(Q_MAX);
            res.sat = 1'b1;
        end else if (r < Q_MIN) begin
            res.q   = Q_W'(Q_MIN);
            res.sat = 1'b1;
        end else begin
            res.q   = r[Q_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_if.sv
// Sample-in / quantized-out bundle of the FIR output stage.
// Handshake: q is transferred on a rising edge when q_vld and q_rdy are both high;
// y_vld is never backpressured.
interface fir_out_if
    import fir_out_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    logic signed [Y_W-1:0]       y;
    logic                        y_vld;
    logic [SH_W-1:0]             shift;
    logic signed [Q_W-1:0]       q;
    logic                        q_vld;
    logic                        q_rdy;
    logic                        sat;
    logic                        drop;
    logic [$clog2(DEPTH):0]      level;

    modport master (
        output y, y_vld, shift, q_rdy,
        input  q, q_vld, sat, drop, level
    );

    modport slave (
        input  y, y_vld, shift, q_rdy,
        output q, q_vld, sat, drop, level
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous first-word fall-through FIFO; rd_data_o reads 0 while empty.
module fir_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_en_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_wr;
    logic         do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;

    // A pop frees the slot in the same edge, so write-while-full is legal with a pop.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: warm-up discard, round/shift/clamp to 8 bits, one register
// stage, then a FWFT FIFO. Optional saturation counter under FIR_OUT_SATCNT_EN.
module fir_out_stage
    import fir_out_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WARMUP = WARMUP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fir_out_if.slave     io
`ifdef FIR_OUT_SATCNT_EN
    ,
    output logic [7:0]   sat_cnt
`endif
);
    localparam int WC_W = $clog2(WARMUP + 2);

    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            warm_done;
    logic            accept;
    quant_t          qr;

    logic            pipe_vld_q, pipe_vld_d;
    logic [Q_W-1:0]  pipe_data_q, pipe_data_d;
    logic            sat_q, sat_d;
    logic            drop_q, drop_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic [Q_W-1:0]  fifo_rd;

    assign warm_done = (wcnt_q == WC_W'(WARMUP));
    assign accept    = io.y_vld && warm_done;
    assign pop       = io.q_vld && io.q_rdy;

    always_comb begin
        qr          = quantize(io.y, io.shift);
        wcnt_d      = wcnt_q;
        if (io.y_vld && !warm_done) wcnt_d = wcnt_q + 1'b1;
        pipe_vld_d  = accept;
        pipe_data_d = qr.q;
        sat_d       = sat_q | (accept & qr.sat);
        // Only the registered sample that arrives at a full, non-popping FIFO is lost.
        drop_d      = drop_q | (pipe_vld_q & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            sat_q       <= sat_d;
            drop_q      <= drop_d;
        end
    end

    fir_out_fifo #(
        .W     (Q_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pipe_vld_q),
        .wr_data_i (pipe_data_q),
        .rd_en_i   (io.q_rdy),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (io.level)
    );

    assign io.q     = fifo_rd;
    assign io.q_vld = !fifo_empty;
    assign io.sat   = sat_q;
    assign io.drop  = drop_q;

`ifdef FIR_OUT_SATCNT_EN
    logic [7:0] satcnt_q, satcnt_d;

    always_comb begin
        satcnt_d = satcnt_q;
        if (accept && qr.sat && satcnt_q != 8'hFF) satcnt_d = satcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) satcnt_q <= '0;
        else     satcnt_q <= satcnt_d;
    end

    assign sat_cnt = satcnt_q;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage (default DEPTH=4, WARMUP=2); define
// FIR_OUT_SATCNT_EN to also exercise the saturation counter.
module tb_fir_out_stage;
    import fir_out_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fir_out_if bus ();

`ifdef FIR_OUT_SATCNT_EN
    logic [7:0] sat_cnt;
`endif

    fir_out_stage dut (
        .clk     (clk),
        .rst     (rst),
        .io      (bus)
`ifdef FIR_OUT_SATCNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.y_vld = 1'b0;
        bus.q_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int yv, input int sh);
        bus.y     = Y_W'(yv);
        bus.shift = SH_W'(sh);
        bus.y_vld = 1'b1;
        tick();
        bus.y_vld = 1'b0;
    endtask

    task automatic warm();
        send(0, 0);
        send(0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int vec_y [5] = '{5, -5, -6, -2048, 2047};
    int vec_s [5] = '{1, 1, 2, 4, 4};
    int vec_q [5] = '{3, -2, -1, -128, 127};

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus.y     = '0;
        bus.shift = '0;
        bus.y_vld = 1'b0;
        bus.q_rdy = 1'b0;

        // Reset values
        do_reset();
        check("rst_q_vld", bus.q_vld, 0);
        check("rst_q", bus.q, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_level", bus.level, 0);
`ifdef FIR_OUT_SATCNT_EN
        check("rst_sat_cnt", sat_cnt, 0);
`endif

        // Warm-up discards the first two; 300 clamps to 127 two cycles later
        bus.q_rdy = 1'b1;
        send(100, 0);
        send(200, 0);
        send(300, 0);
        check("wu_n1_q_vld", bus.q_vld, 0);
        tick();
        check("wu_n2_q_vld", bus.q_vld, 1);
        check("wu_n2_q", bus.q, 127);
        tick();
        check("wu_n3_q_vld", bus.q_vld, 0);
        check("wu_n3_q", bus.q, 0);
        check("wu_sat", bus.sat, 1);
        check("wu_drop", bus.drop, 0);

        // Rounding and clamping stream; sat only after the last vector
        do_reset();
        bus.q_rdy = 1'b1;
        warm();
        idle(2);
        check("rnd_pre_q_vld", bus.q_vld, 0);
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                bus.y     = Y_W'(vec_y[i]);
                bus.shift = SH_W'(vec_s[i]);
                bus.y_vld = 1'b1;
            end else begin
                bus.y_vld = 1'b0;
            end
            tick();
            check($sformatf("rnd_sat_%0d", i), bus.sat, (i >= 4) ? 1 : 0);
            if (i >= 1 && i <= 5) begin
                check($sformatf("rnd_q_vld_%0d", i - 1), bus.q_vld, 1);
                check($sformatf("rnd_q_%0d", i - 1), bus.q, vec_q[i - 1]);
            end else begin
                check($sformatf("rnd_idle_q_vld_%0d", i), bus.q_vld, 0);
            end
        end
        bus.y_vld = 1'b0;

        // Overflow: fifth sample dropped, first four drain in order
        do_reset();
        warm();
        for (int k = 1; k <= 5; k++) send(k, 0);
        idle(2);
        check("ovf_q_vld", bus.q_vld, 1);
        check("ovf_drop", bus.drop, 1);
        check("ovf_level", bus.level, 4);
        bus.q_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_drain_q_%0d", k), bus.q, k);
            tick();
        end
        check("ovf_empty_q_vld", bus.q_vld, 0);
        check("ovf_empty_q", bus.q, 0);
        bus.q_rdy = 1'b0;

        // Write and pop together while full: no drop, level stays 4
        do_reset();
        warm();
        for (int k = 1; k <= 4; k++) send(k, 0);
        idle(2);
        check("wp_full_level", bus.level, 4);
        send(9, 0);
        bus.q_rdy = 1'b1;
        tick();
        bus.q_rdy = 1'b0;
        check("wp_drop", bus.drop, 0);
        check("wp_level", bus.level, 4);
        bus.q_rdy = 1'b1;
        check("wp_q_a", bus.q, 2);
        tick();
        check("wp_q_b", bus.q, 3);
        tick();
        check("wp_q_c", bus.q, 4);
        tick();
        check("wp_q_d", bus.q, 9);
        tick();
        check("wp_end_q_vld", bus.q_vld, 0);
        bus.q_rdy = 1'b0;

        // Mid-operation reset flushes the buffer and restarts warm-up
        do_reset();
        warm();
        for (int k = 1; k <= 3; k++) send(k, 0);
        idle(2);
        check("mr_level_pre", bus.level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_q_vld", bus.q_vld, 0);
        check("mr_q", bus.q, 0);
        send(7, 0);
        send(8, 0);
        idle(3);
        check("mr_warm_q_vld", bus.q_vld, 0);
        send(10, 0);
        tick();
        check("mr_first_q_vld", bus.q_vld, 1);
        check("mr_first_q", bus.q, 10);

`ifdef FIR_OUT_SATCNT_EN
        // Saturation counter holds at 255
        do_reset();
        bus.q_rdy = 1'b1;
        warm();
        for (int k = 0; k < 300; k++) send(32767, 0);
        idle(3);
        check("satcnt_full", sat_cnt, 255);
        send(-32768, 0);
        idle(3);
        check("satcnt_hold", sat_cnt, 255);
        bus.q_rdy = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
